// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared widths, state encoding and constants for the
// sequential 16/8 restoring divider.
package seq_div_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam logic [DIV_DW-1:0] DIV_DBZ_Q = 16'hFFFF;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
// Ports: t (shifted partial remainder), divisor in; r_nxt, qbit out.
module div_step
  import seq_div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW:0]   t,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   r_nxt,
  output logic          qbit
);

  // 9-bit subtract; the extra top bit is the borrow out.
  logic [VW+1:0] diff;

  assign diff  = {1'b0, t} - {2'b00, divisor};
  assign qbit  = ~diff[VW+1];
  assign r_nxt = qbit ? diff[VW:0] : t;

endmodule

// File: rtl/seq_div_16by8.sv
// seq_div_16by8: 16/8 sequential restoring divider, start/busy/done.
// Ports: clk, rst_n, start, dividend, divisor in; busy, done, quotient,
// remainder, dbz, ovf out. Option macro: SEQ_DIV_OVF_CHK_EN (ovf check).
module seq_div_16by8
  import seq_div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  localparam int CW = $clog2(DW);

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] q;
  logic [VW:0]   r;
  logic [VW-1:0] dvs;

  logic [VW:0]   t;
  logic [VW:0]   r_nxt;
  logic          qbit;
  logic [DW-1:0] q_nxt;
  logic          last;
  logic          accept;

  assign t      = {r[VW-1:0], q[DW-1]};
  assign q_nxt  = {q[DW-2:0], qbit};
  assign last   = (cnt == CW'(DW - 1));
  assign accept = (state == IDLE) && start;

  div_step #(
    .VW(VW)
  ) u_step (
    .t      (t),
    .divisor(dvs),
    .r_nxt  (r_nxt),
    .qbit   (qbit)
  );

  // r stays below the divisor, so its top bit is always zero.
  logic unused_rtop;
  assign unused_rtop = ^{r[VW], r_nxt[VW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      r         <= '0;
      dvs       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= DIV_DBZ_Q;
              remainder <= dividend[VW-1:0];
              dbz       <= 1'b1;
            end else begin
              state <= RUN;
              q     <= dividend;
              r     <= '0;
              dvs   <= divisor;
              cnt   <= '0;
              dbz   <= 1'b0;
            end
          end
        end
        RUN: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_nxt;
            remainder <= r_nxt[VW-1:0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_DIV_OVF_CHK_EN
  // Quotient wider than VW bits: dividend is not an 8x8 product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= |q_nxt[DW-1:VW];
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_16by8.sv
// tb_seq_div_16by8: random + directed bench for seq_div_16by8 with an
// arithmetic reference model compared every cycle.
module tb_seq_div_16by8;

`ifdef SEQ_DIV_OVF_CHK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, dbz, ovf;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  int nvec = 0;
  int nerr = 0;

  seq_div_16by8 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .dbz      (dbz),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Reference model: cycles left busy, pending and visible results.
  int          m_left;
  logic [15:0] m_q, m_pq;
  logic [7:0]  m_r, m_pr;
  logic        m_dbz, m_ovf, m_povf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_q    <= '0;
      m_r    <= '0;
      m_dbz  <= 1'b0;
      m_ovf  <= 1'b0;
      m_pq   <= '0;
      m_pr   <= '0;
      m_povf <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_q   <= m_pq;
        m_r   <= m_pr;
        m_ovf <= m_povf;
      end
    end else if (start) begin
      m_ovf <= 1'b0;
      if (divisor == 0) begin
        m_left <= 1;
        m_dbz  <= 1'b1;
        m_q    <= 16'hFFFF;
        m_r    <= dividend[7:0];
      end else begin
        m_left <= 17;
        m_dbz  <= 1'b0;
        m_pq   <= dividend / divisor;
        m_pr   <= 8'(dividend % divisor);
        m_povf <= OVF_EN && ((dividend / divisor) > 255);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_left == 1));
    chk("quotient", 32'(quotient), 32'(m_q));
    chk("remainder", 32'(remainder), 32'(m_r));
    chk("dbz", 32'(dbz), 32'(m_dbz));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  end

  // Launch one op; gat>0 pulses a foreign start at that cycle.
  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                        input bit lit, input logic [15:0] eq,
                        input logic [7:0] er, input logic edbz,
                        input logic eovf, input int elat,
                        input int gat);
    int lat;
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == gat) begin
        start    = 1'b1;
        dividend = 16'd999;
        divisor  = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    if (lit) begin
      chk("latency", 32'(lat), 32'(elat));
      chk("lit_q", 32'(quotient), 32'(eq));
      chk("lit_r", 32'(remainder), 32'(er));
      chk("lit_dbz", 32'(dbz), 32'(edbz));
      chk("lit_ovf", 32'(ovf), 32'(eovf));
    end
    @(posedge clk); #1;
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    rst_n = 1'b1;

    run_op(16'd12345, 8'd100, 1, 16'd123, 8'd45, 1'b0, 1'b0, 17, 0);
    run_op(16'd50000, 8'd250, 1, 16'd200, 8'd0, 1'b0, 1'b0, 17, 0);
    run_op(16'd65535, 8'd1, 1, 16'd65535, 8'd0, 1'b0, OVF_EN, 17, 0);
    run_op(16'h1234, 8'd0, 1, 16'hFFFF, 8'h34, 1'b1, 1'b0, 1, 0);
    run_op(16'd12345, 8'd100, 1, 16'd123, 8'd45, 1'b0, 1'b0, 17, 5);

    // Abort mid-run with reset.
    @(posedge clk); #1;
    start    = 1'b1;
    dividend = 16'd40000;
    divisor  = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(quotient), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    run_op(16'd40000, 8'd3, 1, 16'd13333, 8'd1, 1'b0, OVF_EN, 17, 0);

    // Round-trip 8x8 products.
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(16'(a * b), b, 1, 16'(a), 8'd0, 1'b0, 1'b0, 17, 0);
    end

    // Random operands, occasional zero divisor.
    for (int i = 0; i < 60; i++) begin
      run_op(16'($urandom), (i % 7 == 0) ? 8'd0 : 8'($urandom), 0,
             '0, '0, 1'b0, 1'b0, 0, 0);
    end

    // Start held high with operands changing every cycle.
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start    = 1'b1;
      dividend = 16'($urandom);
      divisor  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
